// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side drain engine.
package fifo_rd_pkg;

    // Skid-buffer occupancy; the encoding doubles as the numeric occupancy.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    localparam int DEFAULT_PKT_LEN = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry registered skid buffer with occupancy FSM. The head entry always
// drives the output; the tail only catches a word while the head is stalled.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         rclk,
    input  logic         rrst,
    input  logic         push,
    input  logic [W-1:0] push_payload,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_payload,
    output logic [1:0]   occ
);

    occ_state_t   state;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         pop;

    assign pop         = (state != OCC_EMPTY) && pop_ready;
    assign out_valid   = (state != OCC_EMPTY);
    assign out_payload = head;
    assign occ         = state;

    // Occupancy FSM and head register; head resets so the output reads 0 before the first push.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state <= OCC_EMPTY;
            head  <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head  <= push_payload;
                        state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head <= push_payload;
                    end else if (push) begin
                        state <= OCC_TWO;
                    end else if (pop) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head  <= tail;
                        state <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

    // Tail entry captures a word only when it arrives behind a stalled head.
    always_ff @(posedge rclk) begin
        if (push && (state == OCC_ONE) && !pop) begin
            tail <= push_payload;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream framed into
// fixed-length packets. Pop requests depend only on registered occupancy,
// never on m_ready.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 12,
    parameter int PKT_LEN   = DEFAULT_PKT_LEN,
    parameter int CNT_W     = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 en,
    input  logic                 rEmpty,
    input  logic [DATA_SIZE-1:0] rData,
    output logic                 rinc,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_last,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [1:0]           occ
);

    localparam int WCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int W      = DATA_SIZE + 1;

    logic [WCNT_W-1:0] wcnt;
    logic              tag_last;
    logic [W-1:0]      head_payload;

    assign rinc     = en && !rEmpty && (occ != 2'd2);
    assign tag_last = (wcnt == WCNT_W'(PKT_LEN - 1));
    assign m_data   = head_payload[DATA_SIZE-1:0];
    assign m_last   = head_payload[DATA_SIZE];

    rd_skid_buf #(
        .W(W)
    ) u_skid (
        .rclk        (rclk),
        .rrst        (rrst),
        .push        (rinc),
        .push_payload({tag_last, rData}),
        .pop_ready   (m_ready),
        .out_valid   (m_valid),
        .out_payload (head_payload),
        .occ         (occ)
    );

    // Word position inside the packet; advances only on actual pops, so stalls keep framing.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            wcnt <= '0;
        end else if (rinc) begin
            wcnt <= tag_last ? '0 : wcnt + WCNT_W'(1);
        end
    end

    // Completed-packet counter bumps when the last-tagged word is accepted downstream.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            pkt_cnt <= '0;
        end else if (m_valid && m_ready && m_last) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FWFT FIFO model.
// A second instance with a 2-bit packet counter shares all inputs.
module tb_fifo_rd_stream;

    logic        rclk = 1'b0;
    logic        rrst = 1'b0;
    logic        en = 1'b0;
    logic        m_ready = 1'b0;
    logic        rEmpty;
    logic [11:0] rData;
    logic        rinc, rinc_w;
    logic        m_valid, m_valid_w;
    logic [11:0] m_data, m_data_w;
    logic        m_last, m_last_w;
    logic [15:0] pkt_cnt;
    logic [1:0]  pkt_cnt_w;
    logic [1:0]  occ, occ_w;

    logic [11:0] fifo_mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    int          pop_count = 0;

    logic [11:0] cap_data [1024];
    logic        cap_last [1024];
    int          cap_count = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_rinc;
        logic        exp_valid;
        logic        chk_data;
        logic [11:0] exp_data;
        logic        exp_last;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t vecs [5];

    fifo_rd_stream #(.DATA_SIZE(12), .PKT_LEN(4), .CNT_W(16)) dut (
        .rclk(rclk), .rrst(rrst), .en(en), .rEmpty(rEmpty), .rData(rData),
        .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .pkt_cnt(pkt_cnt), .occ(occ)
    );

    fifo_rd_stream #(.DATA_SIZE(12), .PKT_LEN(4), .CNT_W(2)) dut_wrap (
        .rclk(rclk), .rrst(rrst), .en(en), .rEmpty(rEmpty), .rData(rData),
        .rinc(rinc_w), .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w),
        .m_last(m_last_w), .pkt_cnt(pkt_cnt_w), .occ(occ_w)
    );

    // Free-running read clock.
    always #5 rclk = ~rclk;

    assign rEmpty = (rd_ptr == wr_ptr);
    assign rData  = fifo_mem[rd_ptr];

    // FIFO model: head consumed on rinc, flushed by the shared reset.
    always @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            rd_ptr <= wr_ptr;
        end else if (rinc) begin
            rd_ptr    <= rd_ptr + 8'd1;
            pop_count <= pop_count + 1;
        end
    end

    // Stream monitor: records every word accepted at the coming edge.
    always @(negedge rclk) begin
        if (rrst && m_valid && m_ready) begin
            cap_data[cap_count] <= m_data;
            cap_last[cap_count] <= m_last;
            cap_count           <= cap_count + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic r);
        @(posedge rclk);
        #1;
        en      = e;
        m_ready = r;
    endtask

    task automatic load_word(input logic [11:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr           = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #2;
        rrst    = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge rclk);
        #3;
        rrst = 1'b1;
    endtask

    task automatic wait_caps(input int base, input int n, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            if (cap_count - base >= n) break;
            @(posedge rclk);
            #1;
        end
        if (cap_count - base < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL stream_timeout: got %0d words, expected %0d", cap_count - base, n);
        end
    endtask

    task automatic check_words(input int base, input int n, input logic [11:0] first);
        for (int i = 0; i < n; i++) begin
            checkOutput("word_data", 32'(cap_data[base + i]), 32'(first + 12'(i)));
            checkOutput("word_last", 32'(cap_last[base + i]), 32'((i % 4) == 3));
        end
        checkOutput("word_count", 32'(cap_count - base), 32'(n));
    endtask

    initial begin
        int base;
        int p0;

        // Cycle table for the fill test: words 101,102,103 preloaded.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h101, 1'b0, 2'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h102, 1'b0, 2'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h103, 1'b0, 2'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 2'd0};

        #2;
        checkOutput("rst_valid", 32'(m_valid), 0);
        checkOutput("rst_data", 32'(m_data), 0);
        checkOutput("rst_last", 32'(m_last), 0);
        checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 0);
        checkOutput("rst_occ", 32'(occ), 0);
        checkOutput("rst_rinc", 32'(rinc), 0);
        @(posedge rclk);
        #3;
        rrst = 1'b1;

        // Reset then fill, one table row per cycle.
        load_word(12'h101);
        load_word(12'h102);
        load_word(12'h103);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(vecs[s].en, vecs[s].rdy);
            @(negedge rclk);
            checkOutput($sformatf("fill%0d_rinc", s), 32'(rinc), 32'(vecs[s].exp_rinc));
            checkOutput($sformatf("fill%0d_valid", s), 32'(m_valid), 32'(vecs[s].exp_valid));
            checkOutput($sformatf("fill%0d_occ", s), 32'(occ), 32'(vecs[s].exp_occ));
            if (vecs[s].chk_data) begin
                checkOutput($sformatf("fill%0d_data", s), 32'(m_data), 32'(vecs[s].exp_data));
                checkOutput($sformatf("fill%0d_last", s), 32'(m_last), 32'(vecs[s].exp_last));
            end
        end

        // Backpressure: ten words queued, downstream stalled.
        do_reset();
        base = cap_count;
        p0   = pop_count;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) load_word(12'h200 + 12'(i));
        repeat (6) @(posedge rclk);
        @(negedge rclk);
        checkOutput("bp_pops", 32'(pop_count - p0), 2);
        checkOutput("bp_occ", 32'(occ), 2);
        checkOutput("bp_rinc", 32'(rinc), 0);
        checkOutput("bp_valid", 32'(m_valid), 1);
        checkOutput("bp_data", 32'(m_data), 32'h200);
        @(negedge rclk);
        checkOutput("bp_data_hold", 32'(m_data), 32'h200);
        applyStimulus(1'b1, 1'b1);
        @(negedge rclk);
        checkOutput("bp_rinc_before_pop", 32'(rinc), 0);
        @(negedge rclk);
        checkOutput("bp_rinc_after_pop", 32'(rinc), 1);
        wait_caps(base, 10, 60);
        repeat (3) @(posedge rclk);
        #1;
        check_words(base, 10, 12'h200);
        checkOutput("bp_total_pops", 32'(pop_count - p0), 10);

        // Framing: twelve words, three packets.
        do_reset();
        base = cap_count;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) load_word(12'h300 + 12'(i));
        wait_caps(base, 12, 60);
        @(negedge rclk);
        checkOutput("frame_pkt_cnt", 32'(pkt_cnt), 3);
        check_words(base, 12, 12'h300);

        // Enable dropped mid-packet: framing must resume in place.
        base = cap_count;
        applyStimulus(1'b1, 1'b1);
        load_word(12'h400);
        load_word(12'h401);
        wait_caps(base, 2, 20);
        en = 1'b0;
        load_word(12'h402);
        load_word(12'h403);
        p0 = pop_count;
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            checkOutput($sformatf("en_off%0d_rinc", c), 32'(rinc), 0);
        end
        checkOutput("en_off_pops", 32'(pop_count - p0), 0);
        applyStimulus(1'b1, 1'b1);
        wait_caps(base, 4, 20);
        @(negedge rclk);
        check_words(base, 4, 12'h400);
        checkOutput("en_pkt_cnt", 32'(pkt_cnt), 4);

        // Fifth packet: 16-bit counter reads 5, 2-bit counter wraps to 1.
        base = cap_count;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) load_word(12'h500 + 12'(i));
        wait_caps(base, 4, 20);
        @(negedge rclk);
        checkOutput("pkt_cnt_5", 32'(pkt_cnt), 5);
        checkOutput("pkt_cnt_wrap", 32'(pkt_cnt_w), 1);

        // Asynchronous reset with a full buffer and a mid-packet word counter.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) load_word(12'h600 + 12'(i));
        repeat (4) @(posedge rclk);
        @(negedge rclk);
        checkOutput("pre_rst_occ", 32'(occ), 2);
        checkOutput("pre_rst_pkt_cnt", 32'(pkt_cnt), 5);
        @(posedge rclk);
        #2;
        rrst = 1'b0;
        #1;
        checkOutput("arst_occ", 32'(occ), 0);
        checkOutput("arst_valid", 32'(m_valid), 0);
        checkOutput("arst_data", 32'(m_data), 0);
        checkOutput("arst_last", 32'(m_last), 0);
        checkOutput("arst_pkt_cnt", 32'(pkt_cnt), 0);
        checkOutput("arst_pkt_cnt_wrap", 32'(pkt_cnt_w), 0);
        checkOutput("arst_rinc", 32'(rinc), 0);
        repeat (2) @(posedge rclk);
        #3;
        rrst = 1'b1;
        base = cap_count;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) load_word(12'h700 + 12'(i));
        wait_caps(base, 4, 20);
        @(negedge rclk);
        check_words(base, 4, 12'h700);
        checkOutput("post_rst_pkt_cnt", 32'(pkt_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the asynchronous FIFO, running entirely in the rclk domain. It pops words from the FIFO read port (rData/rEmpty/rinc) into a 2-entry registered skid buffer. It presents them downstream as a valid/ready stream, framed into fixed-length packets with a last-word flag and a completed-packet counter. No path runs combinationally from m_ready to rinc.

## Interface
- DATA_SIZE, 12, word width; must match the FIFO data width.
- PKT_LEN, 16, words per packet; legal range 2..65535.
- CNT_W, 16, width of the packet counter.

- rclk  input  1  read-domain clock; all state is on its rising edge.
- rrst  input  1  reset, asynchronous, active-low; clock rclk.
- en  input  1  drain enable; 0 stops new pops, buffered words still drain.
- rEmpty  input  1  FIFO empty flag.
- rData  input  DATA_SIZE  FIFO head word, valid whenever rEmpty=0 (first-word-fall-through).
- rinc  output  1  pop request; the FIFO head is consumed at the rclk edge where rinc=1.
- m_valid  output  1  stream word available.
- m_ready  input  1  downstream accepts the word when m_valid=1.
- m_data  output  DATA_SIZE  stream word.
- m_last  output  1  marks word PKT_LEN-1 of each packet.
- pkt_cnt  output  CNT_W  completed packets handed downstream; wraps modulo 2^CNT_W.
- occ  output  2  skid-buffer occupancy, 0..2.

## Operation
- rinc = en & ~rEmpty & (occ != 2), combinational from registered state and inputs; never depends on m_ready.
- Push: rinc=1 at the edge. The word rData is written to the tail, tagged last = (wcnt == PKT_LEN-1).
- wcnt counts from 0 to PKT_LEN-1, advances on each push, and wraps to 0 after the last word.
- Pop: m_valid & m_ready at the edge removes the head entry.
- pkt_cnt increments on a pop whose entry is tagged last.
- Occupancy state machine, with states EMPTY, ONE and TWO:
  - EMPTY: push goes to ONE; otherwise stays EMPTY. Pop is impossible.
  - ONE: push only goes to TWO; pop only goes to EMPTY; push and pop together stay in ONE, with the new word becoming the head.
  - TWO: pop goes to ONE, and the second entry shifts to the head. Push is impossible because rinc=0.
- m_valid = (occ != 0). m_data and m_last always come from the head entry register.
- Held word: while m_valid=1 and m_ready=0, m_data and m_last hold stable. m_valid never drops without a pop.
- en=0 mid-packet: no pops, and wcnt keeps its position. Framing resumes exactly where it stopped, with no truncation or padding.
- FIFO empty mid-packet behaves the same way as en=0.
- Reset, asynchronous and at any point: occ=0, wcnt=0, pkt_cnt=0, and buffered words are discarded. The FIFO is reset in the same domain.

## Timing
- Reset values: rinc=0, m_valid=0, m_data=0, m_last=0, pkt_cnt=0, occ=0.
- Latency: a word popped at edge n has m_valid=1 after edge n, i.e. one cycle.
- Throughput:
  - One word per cycle sustained whenever m_ready=1, en=1 and rEmpty=0.
  - If m_ready drops, the buffer fills to TWO one cycle later and rinc deasserts.
  - When m_ready returns, rinc reasserts in the cycle after the pop.
- pkt_cnt updates on the edge after the accepting handshake.
- Entry payload registers are not reset and are don't-care while their entry is invalid. m_data still reads 0 from reset until the first push.

## Structure
- Package fifo_rd_pkg:
  - typedef enum occ_state_t {OCC_EMPTY, OCC_ONE, OCC_TWO};
  - localparam for the default PKT_LEN.
- Sub-module rd_skid_buf holds the 2-entry buffer, the occupancy FSM and the push/pop/hold logic. Its payload is {last, data}.
- Top level holds rinc generation, wcnt and pkt_cnt.

## Test plan
- Reset then fill: load 3 words, en=1, m_ready=1.
  - rinc is high for 3 cycles.
  - m_data follows 3 words with 1-cycle latency.
  - rEmpty rises, then m_valid falls.
- Backpressure: m_ready=0 with a FIFO of 10 words.
  - Exactly 2 pops occur, occ=2, rinc=0, and m_data holds word 0.
  - After m_ready=1, all 10 words appear in order with no duplicates or loss.
- Framing with PKT_LEN=4: stream 12 words.
  - m_last is high on words 3, 7 and 11.
  - pkt_cnt reads 3 one cycle after the last handshake.
- en toggling mid-packet (PKT_LEN=4): stream 2 words, en=0 for 5 cycles, then 2 more words.
  - No pops while en=0.
  - m_last is high on the 4th word overall.
- Reset mid-operation: assert rrst with occ=2 and pkt_cnt=5.
  - All outputs return to reset values immediately, with no clock required.
  - The first packet after reset asserts m_last on word PKT_LEN-1.
- pkt_cnt wrap (CNT_W=2): complete 5 packets; pkt_cnt reads 1.
